// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: default frame width, default
// transmit FIFO depth and the state type of the transmit flow-control FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_WIDTH    = 8;
   localparam int UART_TX_FIFO_DEPTH = 16;

   // S_IDLE : transmitter free, head frame may be offered
   // S_BUSY : a frame is in the shifter, wait for transmit_done
   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } tx_fifo_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Generic single-clock show-ahead FIFO with occupancy count and a sticky
// overflow flag.
// Ports:
//   clk        in   system clock (rising edge)
//   reset      in   asynchronous active-low reset
//   push       in   write request
//   push_data  in   write data
//   pop        in   read request (ignored while empty)
//   pop_data   out  head entry, combinational read
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  current occupancy
//   overflow   out  sticky: push while full without a pop
//   clr_ovf    in   synchronous clear of overflow
// -----------------------------------------------------------------------------
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter  int DATA_WIDTH = UART_DATA_WIDTH,
   parameter  int DEPTH      = UART_TX_FIFO_DEPTH,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   input  logic                  clr_ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  pop_ok;
   logic                  push_ok;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // A pop frees a slot in the same cycle, so a write at full is still
   // accepted when it coincides with a pop.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // Set has priority over clear so a dropped write is never lost.
      ovf_d = ovf_q;
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (push && !push_ok) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Transmit buffer in front of the UART TX controller. Frames are offered one
// at a time; after the controller loads a frame the next one is withheld
// until transmit_done, so the shifter is never overwritten mid-frame.
// Ports:
//   clk            in   system clock (rising edge)
//   reset          in   asynchronous active-low reset
//   wr_en          in   host write strobe
//   wr_data        in   host byte
//   full           out  FIFO full
//   empty          out  FIFO empty
//   count          out  occupancy
//   overflow       out  sticky write-while-full flag
//   clr_ovf        in   clear overflow
//   tx_data        out  head-of-FIFO frame (show-ahead)
//   valid_out      out  frame available and transmitter free
//   load           in   controller load pulse, pops the head frame
//   transmit_done  in   controller end-of-frame pulse
// -----------------------------------------------------------------------------
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter  int DATA_WIDTH = UART_DATA_WIDTH,
   parameter  int DEPTH      = UART_TX_FIFO_DEPTH,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow,
   input  logic                  clr_ovf,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  valid_out,
   input  logic                  load,
   input  logic                  transmit_done
);

   tx_fifo_state_t state_q, state_d;
   logic           pop;

   // Loads are honoured only while a frame is being offered.
   assign pop = load && valid_out;

   uart_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop),
      .pop_data  (tx_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (pop)           state_d = S_BUSY;
         S_BUSY:  if (transmit_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      valid_out = 1'b0;
      if (state_q == S_IDLE) begin
         valid_out = !empty;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          full, empty, overflow, valid_out;
   logic [CNT_W-1:0] count;
   logic          clr_ovf = 1'b0;
   logic [DW-1:0] tx_data;
   logic          load = 1'b0;
   logic          transmit_done = 1'b0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_en         (wr_en),
      .wr_data       (wr_data),
      .full          (full),
      .empty         (empty),
      .count         (count),
      .overflow      (overflow),
      .clr_ovf       (clr_ovf),
      .tx_data       (tx_data),
      .valid_out     (valid_out),
      .load          (load),
      .transmit_done (transmit_done)
   );

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Behavioural reference: a queue of held bytes, a "transmitter busy" flag
   // and a sticky overflow flag, updated from the interface rules.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] exp_q[$];
   bit m_busy = 1'b0;
   bit m_ovf  = 1'b0;
   bit m_pop, m_wacc, m_busy_pre;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         exp_q.delete();
         m_busy = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         m_busy_pre = m_busy;
         m_pop  = load && !m_busy && (m_q.size() > 0);
         m_wacc = wr_en && ((m_q.size() < DEPTH) || m_pop);
         if (m_pop) void'(m_q.pop_front());
         if (m_wacc) begin
            m_q.push_back(wr_data);
            exp_q.push_back(wr_data);
         end
         if (m_busy_pre && transmit_done) m_busy = 1'b0;
         else if (m_pop)                  m_busy = 1'b1;
         if (wr_en && !m_wacc) m_ovf = 1'b1;
         else if (clr_ovf)     m_ovf = 1'b0;
      end
   end

   // Monitor: status against the model every cycle; presented frames against
   // the scoreboard queue, popped when the controller takes a frame.
   always @(negedge clk) begin
      chk("count", int'(count), m_q.size());
      chk("full", int'(full), int'(m_q.size() == DEPTH));
      chk("empty", int'(empty), int'(m_q.size() == 0));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("valid_out", int'(valid_out), int'(!m_busy && m_q.size() > 0));
      if (valid_out) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_data: valid_out=1 got 0x%0h required no frame at %0t", tx_data, $time);
         end else begin
            chk("tx_data", int'(tx_data), int'(exp_q[0]));
            if (load) void'(exp_q.pop_front());
         end
      end
   end

   // One clock of stimulus, entered and left at posedge+1.
   task automatic cyc(input bit w, input logic [DW-1:0] d, input bit ld, input bit td, input bit clr);
      wr_en = w; wr_data = d; load = ld; transmit_done = td; clr_ovf = clr;
      @(posedge clk);
      #1;
      wr_en = 1'b0; load = 1'b0; transmit_done = 1'b0; clr_ovf = 1'b0;
   endtask

   initial begin
      // Reset then idle
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_valid", int'(valid_out), 0);
      chk("rst_ovf", int'(overflow), 0);
      reset = 1'b1;
      repeat (10) cyc(0, '0, 0, 0, 0);
      chk("idle_empty", int'(empty), 1);

      // Single frame, one-cycle write latency, held in busy without done
      cyc(1, 8'hA5, 0, 0, 0);
      chk("single_valid", int'(valid_out), 1);
      chk("single_data", int'(tx_data), 8'hA5);
      cyc(0, '0, 1, 0, 0);
      chk("single_count", int'(count), 0);
      chk("single_valid0", int'(valid_out), 0);
      repeat (50) cyc(0, '0, 0, 0, 0);
      chk("single_hold", int'(valid_out), 0);
      cyc(0, '0, 0, 1, 0);

      // Back-to-back frames gated by transmit_done
      cyc(1, 8'h11, 0, 0, 0);
      cyc(1, 8'h22, 0, 0, 0);
      cyc(1, 8'h33, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, '0, 1, 0, 0);
         cyc(0, '0, 0, 0, 0);
         chk("b2b_wait", int'(valid_out), 0);
         cyc(0, '0, 0, 1, 0);
         chk("b2b_valid", int'(valid_out), int'(k < 2));
         if (k == 0) chk("b2b_data22", int'(tx_data), 8'h22);
      end

      // Fill, overflow, pop+write at full, drain across the pointer wrap
      for (int i = 0; i < DEPTH; i++) cyc(1, DW'(8'h40 + i), 0, 0, 0);
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), DEPTH);
      cyc(1, 8'hFF, 0, 0, 0);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_count", int'(count), DEPTH);
      cyc(1, 8'h77, 1, 0, 0);
      chk("popwr_count", int'(count), DEPTH);
      cyc(0, '0, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, '0, 1, 0, 0);
         cyc(0, '0, 0, 1, 0);
      end
      chk("drain_empty", int'(empty), 1);
      chk("drain_ovf_sticky", int'(overflow), 1);
      cyc(0, '0, 0, 0, 1);
      chk("clr_ovf", int'(overflow), 0);

      // Ignored strobes
      cyc(0, '0, 1, 0, 0);
      chk("ld_empty_count", int'(count), 0);
      cyc(1, 8'h5A, 0, 0, 0);
      cyc(1, 8'h5B, 0, 0, 0);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 1, 0, 0);
      chk("ld_busy_count", int'(count), 1);
      cyc(0, '0, 0, 1, 0);
      cyc(0, '0, 0, 1, 0);
      chk("td_idle_valid", int'(valid_out), 1);
      chk("td_idle_data", int'(tx_data), 8'h5B);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 0, 1, 0);

      // Asynchronous reset in the middle of a frame
      for (int i = 0; i < 6; i++) cyc(1, DW'(8'hC0 + i), 0, 0, 0);
      cyc(0, '0, 1, 0, 0);
      chk("mid_count5", int'(count), 5);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_valid", int'(valid_out), 0);
      chk("arst_empty", int'(empty), 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc(1, 8'h3C, 0, 0, 0);
      chk("post_rst_valid", int'(valid_out), 1);
      chk("post_rst_data", int'(tx_data), 8'h3C);
      cyc(0, '0, 1, 0, 0);
      cyc(0, '0, 0, 1, 0);

      // Randomized traffic with varying write pressure
      for (int ph = 0; ph < 4; ph++) begin
         int wprob;
         wprob = (ph == 0) ? 90 : (ph == 1) ? 20 : (ph == 2) ? 60 : 45;
         for (int n = 0; n < 1000; n++) begin
            cyc(($urandom % 100) < wprob, DW'($urandom),
                $urandom % 2, ($urandom % 4) == 0, ($urandom % 50) == 0);
         end
      end
      repeat (40) cyc(0, '0, 1, 1, 0);
      chk("final_empty", int'(empty), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
